branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

EX-stage branch resolution block for the pipelined processor. Consumes the `isNotEqual`/`isLessThan` flags from the 32-bit look-ahead comparator, together with the decoded branch type, PC and immediate of the instruction in EX. Produces a registered fetch redirect and a multi-cycle wrong-path flush. Keeps free-running branch/taken statistics counters.

## Interface
Parameters:
- `PC_W`, 32, PC width in bits; PC is word-addressed.
- `IMM_W`, 17, branch immediate width in bits, signed.
- `SQUASH_CYCLES`, 2, number of cycles `flush` is asserted per taken branch; legal range 1..7.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on the `clock` rising edge.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_is_bne`  in  1  EX instruction is `bne`.
- `ex_is_blt`  in  1  EX instruction is `blt`.
- `ex_pc`  in  PC_W  PC of the EX instruction.
- `ex_imm`  in  IMM_W  signed branch offset.
- `cmp_isNotEqual`  in  1  comparator output for the EX operands.
- `cmp_isLessThan`  in  1  comparator output for the EX operands.
- `stall`  in  1  pipeline hold; EX contents are not advancing this cycle.
- `redirect_valid`  out  1  one-cycle pulse: fetch loads `redirect_pc`.
- `redirect_pc`  out  PC_W  branch target.
- `flush`  out  1  squash IF/ID and ID/EX contents.
- `branch_count`  out  32  resolved branches.
- `taken_count`  out  32  taken branches.

## Operation
- `is_br` = `ex_is_bne | ex_is_blt`.
- `taken` = `(ex_is_bne & cmp_isNotEqual) | (ex_is_blt & cmp_isLessThan)`.
- If both type bits are set (illegal encoding), the OR above applies and the branch is counted once.
- Target = `ex_pc + 1 + sext(ex_imm)`, computed modulo 2^PC_W; wraps silently.
- A branch is resolved when `ex_valid & is_br & ~stall` holds in state IDLE.
- State machine IDLE / REDIRECT / SQUASH, with a squash counter `sq` (3 bits):
  - IDLE:
    - Resolved and taken → REDIRECT; register the target into `redirect_pc`; `sq` ← SQUASH_CYCLES−1.
    - Resolved and not taken → stay in IDLE; increment `branch_count` only.
  - REDIRECT (lasts exactly 1 cycle, regardless of `stall`):
    - `redirect_valid`=1, `flush`=1.
    - Next state is SQUASH if `sq`≠0, else IDLE.
  - SQUASH:
    - `flush`=1.
    - If `stall`=0: decrement `sq`; when `sq` reaches 1→0, go to IDLE on the following edge.
    - If `stall`=1: `sq` holds and `flush` stays asserted.
- Any instruction seen in EX during REDIRECT or SQUASH is wrong-path: it is not resolved, not counted and cannot trigger a redirect.
- Counters:
  - `branch_count` increments on every resolution.
  - `taken_count` increments on resolution with `taken`=1.
  - Both increment in the same edge that leaves IDLE; both wrap 2^32−1 → 0.
- Redirect has priority over `stall` at the fetch stage; this block does not gate `redirect_valid` with `stall`.

## Timing
- Reset (`reset`=0 at an edge), from any state including mid-SQUASH:
  - Next cycle: state IDLE, `sq`=0.
  - `redirect_valid`=0, `flush`=0, `redirect_pc`=0, `branch_count`=0, `taken_count`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: taken branch resolved in cycle T → `redirect_valid` high in T+1 only.
  - `flush` high in T+1 … T+SQUASH_CYCLES, plus one extra cycle for each stalled SQUASH cycle.
  - Counters reflect the branch in T+1.
- Back-to-back branches: the earliest possible next resolution is cycle T+SQUASH_CYCLES+1.
- `redirect_pc` holds its last value outside REDIRECT.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, then 1 with no `ex_valid` → all outputs 0 for 10 cycles.
- Taken bne: `ex_pc`=0x100, `ex_imm`=5, `ex_is_bne`=1, `cmp_isNotEqual`=1 in cycle T → `redirect_pc`=0x106 with `redirect_valid`=1 in T+1 only; `flush`=1 in T+1 and T+2; `branch_count`=1, `taken_count`=1.
- Not-taken and negative offset:
  - blt with `cmp_isLessThan`=0 → no redirect, no flush, `branch_count`+1.
  - Then blt taken with `ex_pc`=0x10, `ex_imm`=−3 (0x1FFFD) → `redirect_pc`=0x0E.
- Wrong-path suppression and stall: taken branch in T; a taken-looking bne in EX at T+1 and T+2; `stall`=1 in T+2 → single `redirect_valid` pulse; `flush` high T+1…T+3; counters increment by 1 only.
- Wrap-around:
  - `ex_pc`=0xFFFFFFFF, `ex_imm`=0, taken → `redirect_pc`=0x00000000.
  - Preload the counters to 0xFFFFFFFF via 2^32 resolutions or a force → the next taken branch yields 0.
- Reset mid-operation: assert `reset`=0 in T+1 of a taken branch → in T+2 `flush`=0 and `redirect_valid`=0, counters 0; a branch resolved in T+3 behaves normally.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: turns comparator flags plus the decoded branch type
// into a registered fetch redirect, a multi-cycle wrong-path flush and branch statistics.
module branch_resolve_unit #(
    parameter int PC_W          = 32,
    parameter int IMM_W         = 17,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_is_bne,
    input  logic              ex_is_blt,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [IMM_W-1:0]  ex_imm,
    input  logic              cmp_isNotEqual,
    input  logic              cmp_isLessThan,
    input  logic              stall,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush,
    output logic [31:0]       branch_count,
    output logic [31:0]       taken_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      sq;
    logic [2:0]      sq_nxt;
    logic            is_br;
    logic            taken;
    logic            resolve;
    logic [PC_W-1:0] target;

    assign is_br   = ex_is_bne | ex_is_blt;
    assign taken   = (ex_is_bne & cmp_isNotEqual) | (ex_is_blt & cmp_isLessThan);
    // Only IDLE can resolve; anything in EX while redirecting or squashing is wrong-path.
    assign resolve = ex_valid & is_br & ~stall & (state == IDLE);
    assign target  = ex_pc + PC_W'(1) + {{(PC_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};

    always_comb begin
        state_nxt = state;
        sq_nxt    = sq;
        case (state)
            IDLE: begin
                if (resolve && taken) begin
                    state_nxt = REDIRECT;
                    sq_nxt    = SQ_INIT;
                end
            end
            REDIRECT: begin
                state_nxt = (sq != 3'd0) ? SQUASH : IDLE;
            end
            SQUASH: begin
                if (!stall) begin
                    sq_nxt = sq - 3'd1;
                    if (sq <= 3'd1) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sq_nxt    = 3'd0;
            end
        endcase
    end

    // Outputs are flopped from the next-state decode so they carry no input-to-output path.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            sq             <= 3'd0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            branch_count   <= 32'd0;
            taken_count    <= 32'd0;
        end else begin
            state          <= state_nxt;
            sq             <= sq_nxt;
            redirect_valid <= (state_nxt == REDIRECT);
            flush          <= (state_nxt != IDLE);
            if (resolve && taken) begin
                redirect_pc <= target;
            end
            if (resolve) begin
                branch_count <= branch_count + 32'd1;
            end
            if (resolve && taken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: redirect timing, flush length,
// wrong-path suppression, target/counter wrap-around and mid-operation reset.
module tb_branch_resolve_unit;

    logic        clock;
    logic        reset;
    logic        ex_valid;
    logic        ex_is_bne;
    logic        ex_is_blt;
    logic [31:0] ex_pc;
    logic [16:0] ex_imm;
    logic        cmp_isNotEqual;
    logic        cmp_isLessThan;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    int checks   = 0;
    int failures = 0;

    branch_resolve_unit #(
        .PC_W(32),
        .IMM_W(17),
        .SQUASH_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ex_valid(ex_valid),
        .ex_is_bne(ex_is_bne),
        .ex_is_blt(ex_is_blt),
        .ex_pc(ex_pc),
        .ex_imm(ex_imm),
        .cmp_isNotEqual(cmp_isNotEqual),
        .cmp_isLessThan(cmp_isLessThan),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .flush(flush),
        .branch_count(branch_count),
        .taken_count(taken_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic v, input logic bne, input logic blt,
                                 input logic [31:0] pc, input logic [16:0] imm,
                                 input logic ne, input logic lt, input logic st);
        ex_valid       = v;
        ex_is_bne      = bne;
        ex_is_blt      = blt;
        ex_pc          = pc;
        ex_imm         = imm;
        cmp_isNotEqual = ne;
        cmp_isLessThan = lt;
        stall          = st;
    endtask

    task automatic clearStimulus();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one cycle; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic rv, input logic fl,
                            input logic [31:0] pc, input logic [31:0] bc,
                            input logic [31:0] tc);
        checkOutput({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
        checkOutput({tag, ".flush"},          {31'd0, flush},          {31'd0, fl});
        checkOutput({tag, ".redirect_pc"},    redirect_pc,             pc);
        checkOutput({tag, ".branch_count"},   branch_count,            bc);
        checkOutput({tag, ".taken_count"},    taken_count,             tc);
    endtask

    initial begin
        reset = 1'b0;
        clearStimulus();
        tick();
        tick();
        reset = 1'b1;
        checkAll("reset", 1'b0, 1'b0, 32'h0, 32'd0, 32'd0);

        for (int i = 0; i < 10; i++) begin
            tick();
            checkAll("idle", 1'b0, 1'b0, 32'h0, 32'd0, 32'd0);
        end

        $display("[TB] taken bne");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 17'd5, 1'b1, 1'b0, 1'b0);
        tick();
        clearStimulus();
        checkAll("bne.T1", 1'b1, 1'b1, 32'h106, 32'd1, 32'd1);
        tick();
        checkAll("bne.T2", 1'b0, 1'b1, 32'h106, 32'd1, 32'd1);
        tick();
        checkAll("bne.T3", 1'b0, 1'b0, 32'h106, 32'd1, 32'd1);

        $display("[TB] not-taken blt then negative offset");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h500, 17'd7, 1'b1, 1'b0, 1'b0);
        tick();
        clearStimulus();
        checkAll("blt_nt", 1'b0, 1'b0, 32'h106, 32'd2, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 17'h1FFFD, 1'b0, 1'b1, 1'b0);
        tick();
        clearStimulus();
        checkAll("blt_neg.T1", 1'b1, 1'b1, 32'h0E, 32'd3, 32'd2);
        tick();
        tick();
        checkAll("blt_neg.T3", 1'b0, 1'b0, 32'h0E, 32'd3, 32'd2);

        $display("[TB] wrong-path suppression with stall");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h200, 17'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkAll("wp.T1", 1'b1, 1'b1, 32'h201, 32'd4, 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 17'd9, 1'b1, 1'b0, 1'b0);
        tick();
        checkAll("wp.T2", 1'b0, 1'b1, 32'h201, 32'd4, 32'd3);
        stall = 1'b1;
        tick();
        checkAll("wp.T3", 1'b0, 1'b1, 32'h201, 32'd4, 32'd3);
        stall = 1'b0;
        tick();
        clearStimulus();
        checkAll("wp.T4", 1'b0, 1'b0, 32'h201, 32'd4, 32'd3);

        $display("[TB] target wrap-around");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 17'd0, 1'b1, 1'b0, 1'b0);
        tick();
        clearStimulus();
        checkAll("pcwrap.T1", 1'b1, 1'b1, 32'h0, 32'd5, 32'd4);
        tick();
        tick();

        $display("[TB] counter wrap-around");
        force dut.branch_count = 32'hFFFFFFFF;
        force dut.taken_count  = 32'hFFFFFFFF;
        #1;
        release dut.branch_count;
        release dut.taken_count;
        checkOutput("preload.branch_count", branch_count, 32'hFFFFFFFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 17'd3, 1'b0, 1'b1, 1'b0);
        tick();
        clearStimulus();
        checkAll("cntwrap.T1", 1'b1, 1'b1, 32'h24, 32'd0, 32'd0);
        tick();
        tick();

        $display("[TB] illegal encoding counted once");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1000, 17'h1FFFF, 1'b0, 1'b1, 1'b0);
        tick();
        clearStimulus();
        checkAll("both.T1", 1'b1, 1'b1, 32'h1000, 32'd1, 32'd1);
        tick();
        tick();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h80, 17'd1, 1'b1, 1'b0, 1'b0);
        tick();
        clearStimulus();
        checkAll("rstmid.T1", 1'b1, 1'b1, 32'h82, 32'd2, 32'd2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkAll("rstmid.T2", 1'b0, 1'b0, 32'h0, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 17'd2, 1'b1, 1'b0, 1'b0);
        tick();
        clearStimulus();
        checkAll("rstmid.T4", 1'b1, 1'b1, 32'h43, 32'd1, 32'd1);
        tick();
        checkAll("rstmid.T5", 1'b0, 1'b1, 32'h43, 32'd1, 32'd1);
        tick();
        checkAll("rstmid.T6", 1'b0, 1'b0, 32'h43, 32'd1, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
